// File: rtl/nes_poll_scheduler.sv
// APB3 scheduler that polls two NES-style pads on a shared latch/clock pair.
// Generates the latch/clock waveform from a poll timer or a software trigger,
// captures both 8-bit button words atomically, and keeps sticky new-data,
// overrun and press-event flags.
module nes_poll_scheduler #(
  parameter int unsigned HALF = 4  // PCLK cycles per half bit period, >= 4
) (
  input  logic        PCLK,
  input  logic        PRESERN,  // async, active-high despite the name
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        latch,
  output logic        clock,
  input  logic        data0,
  input  logic        data1
);

  localparam int unsigned CntW = $clog2(2 * HALF);
  localparam logic [CntW-1:0] HalfLast  = CntW'(HALF - 1);
  localparam logic [CntW-1:0] LatchLast = CntW'(2 * HALF - 1);

  localparam logic [7:0] AddrCtrl   = 8'h00;
  localparam logic [7:0] AddrPeriod = 8'h04;
  localparam logic [7:0] AddrPad0   = 8'h08;
  localparam logic [7:0] AddrPad1   = 8'h0C;
  localparam logic [7:0] AddrStatus = 8'h10;
  localparam logic [7:0] AddrEvents = 8'h14;

  typedef enum logic [2:0] {StIdle, StLatch, StLow, StHigh, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            latch_q, latch_d;
  logic            clock_q, clock_d;

  logic            en_q, en_d;
  logic [15:0]     period_q, period_d;
  logic [15:0]     timer_q, timer_d;
  logic            trig_q, trig_d;
  logic [7:0]      pad0_q, pad0_d;
  logic [7:0]      pad1_q, pad1_d;
  logic            new_q, new_d;
  logic            ovr_q, ovr_d;
  logic [7:0]      ev0_q, ev0_d;
  logic [7:0]      ev1_q, ev1_d;
  logic [1:0]      sync0_q, sync0_d;
  logic [1:0]      sync1_q, sync1_d;
  logic [7:0]      sh0_q, sh0_d;
  logic [7:0]      sh1_q, sh1_d;

  logic        wr_en, wr_ctrl, wr_period, wr_status, wr_events;
  logic        busy, done, sample, expired, start, start_take;
  logic [15:0] period_m1;
  logic        unused_pwdata;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign latch   = latch_q;
  assign clock   = clock_q;

  assign unused_pwdata = ^PWDATA[31:16];

  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign wr_ctrl   = wr_en & (PADDR == AddrCtrl);
  assign wr_period = wr_en & (PADDR == AddrPeriod);
  assign wr_status = wr_en & (PADDR == AddrStatus);
  assign wr_events = wr_en & (PADDR == AddrEvents);

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  // PERIOD of 0 or 1 both mean back-to-back polls.
  assign period_m1  = period_q - 16'd1;
  assign expired    = (period_q == 16'd0) || (timer_q >= period_m1);
  assign start      = (en_q & expired) | trig_q;
  assign start_take = (state_q == StIdle) & start;

  // FSM state register.
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  // FSM next state: phase lengths are counted in cnt_q, bit index in bit_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    sample  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (start) state_d = StLatch;
      end
      StLatch: begin
        if (cnt_q == LatchLast) begin
          cnt_d   = '0;
          state_d = StLow;
        end
      end
      StLow: begin
        // Last LOW cycle: data has been stable for at least HALF cycles.
        if (cnt_q == HalfLast) begin
          sample  = 1'b1;
          cnt_d   = '0;
          state_d = (bit_q == 3'd7) ? StDone : StHigh;
        end
      end
      StHigh: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = bit_q + 3'd1;
          state_d = StLow;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // FSM outputs, decoded from the next state so the pins are flop-driven.
  always_comb begin
    latch_d = (state_d == StLatch);
    clock_d = (state_d == StHigh);
  end

  // Registered pad outputs; async reset forces them low mid-poll.
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      latch_q <= 1'b0;
      clock_q <= 1'b0;
    end else begin
      latch_q <= latch_d;
      clock_q <= clock_d;
    end
  end

  // Synchronizers and capture shift registers; first bit ends in bit 7.
  always_comb begin
    sync0_d = {sync0_q[0], data0};
    sync1_d = {sync1_q[0], data1};
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    if (sample) begin
      sh0_d = {sh0_q[6:0], ~sync0_q[1]};
      sh1_d = {sh1_q[6:0], ~sync1_q[1]};
    end
  end

  // Control, timer and trigger-pending next state.
  always_comb begin
    en_d     = en_q;
    period_d = period_q;
    trig_d   = trig_q;
    timer_d  = timer_q;
    if (wr_ctrl) en_d = PWDATA[0];
    if (wr_period) period_d = PWDATA[15:0];
    if (start_take) trig_d = 1'b0;
    if (wr_ctrl && PWDATA[1]) trig_d = 1'b1;
    // Restart at each poll start so expiries land PERIOD cycles apart; the
    // count saturates so an expiry during a poll is held until IDLE.
    if (!en_q) begin
      timer_d = '0;
    end else if (start_take) begin
      timer_d = '0;
    end else if (timer_q != 16'hFFFF) begin
      timer_d = timer_q + 16'd1;
    end
  end

  // Pad words, sticky status and press events; a DONE set beats a W1C.
  always_comb begin
    pad0_d = pad0_q;
    pad1_d = pad1_q;
    new_d  = new_q;
    ovr_d  = ovr_q;
    ev0_d  = ev0_q;
    ev1_d  = ev1_q;
    if (wr_status) begin
      if (PWDATA[1]) new_d = 1'b0;
      if (PWDATA[2]) ovr_d = 1'b0;
    end
    if (wr_events) begin
      ev0_d = ev0_q & ~PWDATA[7:0];
      ev1_d = ev1_q & ~PWDATA[15:8];
    end
    if (done) begin
      pad0_d = sh0_q;
      pad1_d = sh1_q;
      new_d  = 1'b1;
      if (new_q) ovr_d = 1'b1;
      ev0_d  = ev0_d | (sh0_q & ~pad0_q);
      ev1_d  = ev1_d | (sh1_q & ~pad1_q);
    end
  end

  // Register bank, synchronizers and shift registers.
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      en_q     <= 1'b0;
      period_q <= '0;
      timer_q  <= '0;
      trig_q   <= 1'b0;
      pad0_q   <= '0;
      pad1_q   <= '0;
      new_q    <= 1'b0;
      ovr_q    <= 1'b0;
      ev0_q    <= '0;
      ev1_q    <= '0;
      sync0_q  <= '0;
      sync1_q  <= '0;
      sh0_q    <= '0;
      sh1_q    <= '0;
    end else begin
      en_q     <= en_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      trig_q   <= trig_d;
      pad0_q   <= pad0_d;
      pad1_q   <= pad1_d;
      new_q    <= new_d;
      ovr_q    <= ovr_d;
      ev0_q    <= ev0_d;
      ev1_q    <= ev1_d;
      sync0_q  <= sync0_d;
      sync1_q  <= sync1_d;
      sh0_q    <= sh0_d;
      sh1_q    <= sh1_d;
    end
  end

  // Combinational read mux; zero whenever no read is selected.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        AddrCtrl:   PRDATA = {31'd0, en_q};
        AddrPeriod: PRDATA = {16'd0, period_q};
        AddrPad0:   PRDATA = {24'd0, pad0_q};
        AddrPad1:   PRDATA = {24'd0, pad1_q};
        AddrStatus: PRDATA = {29'd0, ovr_q, new_q, busy};
        AddrEvents: PRDATA = {16'd0, ev1_q, ev0_q};
        default:    PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Directed bench for nes_poll_scheduler with a behavioural two-pad model.
module tb_nes_poll_scheduler;

  localparam int unsigned HALF = 4;

  localparam logic [7:0] ACtrl   = 8'h00;
  localparam logic [7:0] APeriod = 8'h04;
  localparam logic [7:0] APad0   = 8'h08;
  localparam logic [7:0] APad1   = 8'h0C;
  localparam logic [7:0] AStatus = 8'h10;
  localparam logic [7:0] AEvents = 8'h14;

  logic        PCLK    = 1'b0;
  logic        PRESERN = 1'b1;
  logic        PSEL    = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE  = 1'b0;
  logic [7:0]  PADDR   = 8'h00;
  logic [31:0] PWDATA  = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        latch;
  logic        clock;
  logic        data0 = 1'b1;
  logic        data1 = 1'b1;

  nes_poll_scheduler #(.HALF(HALF)) dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .latch   (latch),
    .clock   (clock),
    .data0   (data0),
    .data1   (data1)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_mis = 0;

  // Monitor and pad model: edge index, latch rises, pulse counts, serial data.
  int         cyc        = 0;
  int         rises[$];
  int         latch_hi   = 0;
  int         clk_rise   = 0;
  int         pidx       = 8;
  logic       latch_prev = 1'b0;
  logic       clock_prev = 1'b0;
  logic [7:0] p0         = 8'h00;
  logic [7:0] p1         = 8'h00;

  always @(posedge PCLK) begin
    cyc++;
    #1;
    if (latch && !latch_prev) rises.push_back(cyc);
    if (latch) latch_hi++;
    if (clock && !clock_prev) clk_rise++;
    if (latch) pidx = 0;
    else if (clock && !clock_prev) pidx++;
    latch_prev = latch;
    clock_prev = clock;
    data0 = (pidx < 8) ? ~p0[7-pidx] : 1'b1;
    data1 = (pidx < 8) ? ~p1[7-pidx] : 1'b1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    apb_read(a, v);
    check_val(tag, v, exp);
  endtask

  task automatic wait_rises(input int target, input int budget, output int at);
    int n = 0;
    while (rises.size() < target && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    if (rises.size() < target) begin
      check_val("rise_timeout", 32'(rises.size()), 32'(target));
      at = 0;
    end else begin
      at = rises[target-1];
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge PCLK);
  endtask

  task automatic do_poll();
    int nr;
    int r;
    nr = rises.size();
    apb_write(ACtrl, 32'h2);
    wait_rises(nr + 1, 20, r);
    repeat (75) @(negedge PCLK);
  endtask

  task automatic check_all_zero(input string pfx);
    rd_chk({pfx, "_ctrl"}, ACtrl, 32'h0);
    rd_chk({pfx, "_period"}, APeriod, 32'h0);
    rd_chk({pfx, "_pad0"}, APad0, 32'h0);
    rd_chk({pfx, "_pad1"}, APad1, 32'h0);
    rd_chk({pfx, "_status"}, AStatus, 32'h0);
    rd_chk({pfx, "_events"}, AEvents, 32'h0);
  endtask

  initial begin
    int nr, r, r2, l0, c0;

    // Reset and idle behaviour.
    repeat (3) @(negedge PCLK);
    check_val("rst_latch", 32'(latch), 32'h0);
    check_val("rst_clock", 32'(clock), 32'h0);
    PRESERN = 1'b0;
    @(negedge PCLK);
    #1 check_val("prdata_idle", PRDATA, 32'h0);
    check_all_zero("rst");
    rd_chk("unmapped", 8'h18, 32'h0);
    nr = rises.size();
    repeat (100) @(negedge PCLK);
    check_val("no_poll_en0", 32'(rises.size() - nr), 32'h0);

    // Single trigger: pad0 A only, pad1 nothing.
    p0 = 8'h80; p1 = 8'h00;
    l0 = latch_hi; c0 = clk_rise; nr = rises.size();
    do_poll();
    check_val("trig_latch_len", 32'(latch_hi - l0), 32'd8);
    check_val("trig_clk_pulses", 32'(clk_rise - c0), 32'd7);
    check_val("trig_one_poll", 32'(rises.size() - nr), 32'd1);
    rd_chk("trig_pad0", APad0, 32'h80);
    rd_chk("trig_pad1", APad1, 32'h00);
    rd_chk("trig_status", AStatus, 32'h2);
    rd_chk("trig_events", AEvents, 32'h0080);

    // W1C clears.
    apb_write(AStatus, 32'h6);
    apb_write(AEvents, 32'hFFFF);
    rd_chk("w1c_status", AStatus, 32'h0);
    rd_chk("w1c_events", AEvents, 32'h0);

    // Press edges on pad1, and overrun from two unacknowledged polls.
    p1 = 8'h03;
    do_poll();
    rd_chk("edge1_events", AEvents, 32'h0300);
    rd_chk("edge1_pad1", APad1, 32'h03);
    rd_chk("edge1_status", AStatus, 32'h2);
    p1 = 8'h05;
    do_poll();
    rd_chk("edge2_events", AEvents, 32'h0700);
    rd_chk("edge2_pad1", APad1, 32'h05);
    rd_chk("ovr_status", AStatus, 32'h6);

    // W1C of NEW/OVERRUN committing on the same edge as a third DONE.
    nr = rises.size();
    apb_write(ACtrl, 32'h2);
    wait_rises(nr + 1, 20, r);
    wait_until(r + 67);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = AStatus; PWDATA = 32'h6;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    rd_chk("set_wins_status", AStatus, 32'h6);
    apb_write(AStatus, 32'h6);
    rd_chk("w1c2_status", AStatus, 32'h0);

    // TRIG while busy: second poll right after the first returns to IDLE.
    p0 = 8'h41;
    nr = rises.size();
    apb_write(ACtrl, 32'h2);
    wait_rises(nr + 1, 20, r);
    wait_until(r + 20);
    apb_write(ACtrl, 32'h2);
    rd_chk("busy_status", AStatus, 32'h1);
    rd_chk("busy_pad0_a", APad0, 32'h80);
    wait_until(r + 60);
    rd_chk("busy_pad0_b", APad0, 32'h80);
    wait_rises(nr + 2, 40, r2);
    check_val("trig_pending_gap", 32'(r2 - r), 32'd70);
    repeat (75) @(negedge PCLK);
    rd_chk("busy_pad0_new", APad0, 32'h41);
    check_val("busy_two_polls", 32'(rises.size() - nr), 32'd2);

    // Periodic polling.
    apb_write(AStatus, 32'h6);
    apb_write(APeriod, 32'd200);
    nr = rises.size();
    apb_write(ACtrl, 32'h1);
    wait_rises(nr + 3, 800, r);
    if (rises.size() >= nr + 3) begin
      check_val("period200_a", 32'(rises[nr+1] - rises[nr]), 32'd200);
      check_val("period200_b", 32'(rises[nr+2] - rises[nr+1]), 32'd200);
    end
    apb_write(APeriod, 32'd10);
    rd_chk("period_rd", APeriod, 32'd10);
    nr = rises.size();
    wait_rises(nr + 3, 300, r);
    if (rises.size() >= nr + 3) begin
      check_val("period10_gap", 32'(rises[nr+2] - rises[nr+1]), 32'd70);
    end

    // Reset mid-poll while latch is high.
    nr = rises.size();
    wait_rises(nr + 1, 100, r);
    wait_until(r + 3);
    check_val("pre_rst_latch", 32'(latch), 32'h1);
    PRESERN = 1'b1;
    #1;
    check_val("midrst_latch", 32'(latch), 32'h0);
    check_val("midrst_clock", 32'(clock), 32'h0);
    @(negedge PCLK);
    PRESERN = 1'b0;
    check_all_zero("midrst");
    nr = rises.size();
    repeat (200) @(negedge PCLK);
    check_val("midrst_no_poll", 32'(rises.size() - nr), 32'h0);

    // Reset mid-poll while clock is high.
    nr = rises.size();
    apb_write(ACtrl, 32'h2);
    wait_rises(nr + 1, 20, r);
    wait_until(r + 13);
    check_val("pre_rst_clock", 32'(clock), 32'h1);
    PRESERN = 1'b1;
    #1;
    check_val("midrst2_clock", 32'(clock), 32'h0);
    check_val("midrst2_latch", 32'(latch), 32'h0);
    @(negedge PCLK);
    PRESERN = 1'b0;
    repeat (80) @(negedge PCLK);
    rd_chk("midrst2_pad0", APad0, 32'h0);
    rd_chk("midrst2_status", AStatus, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
